// File: rtl/boreal_sram_pkg.sv
// Shared types and helpers for the boreal SRAM bridge.
// Response record layout and the address legality check.
package boreal_sram_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  function automatic logic addr_bad(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] words
  );
    logic [31:0] off;
    off = addr - base;
    return (off >= words * WORD_BYTES) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/boreal_rsp_fifo.sv
// Response FIFO with async reset; head is read straight from storage.
// When empty the head shows the last popped entry, so outputs hold.
module boreal_rsp_fifo #(
  parameter int unsigned W  = 33,
  parameter int unsigned D  = 4,
  localparam int unsigned AW = $clog2(D),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(D));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? mem_q[rptr_q - AW'(1)]
                           : mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(D); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/boreal_sram_bridge.sv
// Valid/ready front-end for the 32-bit SRAM tile: address check,
// one-cycle response stage, credit-based response FIFO, error counter.
module boreal_sram_bridge
  import boreal_sram_pkg::*;
#(
  parameter int unsigned WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_req_valid,
  output logic        m_req_ready,
  input  logic        m_req_we,
  input  logic [31:0] m_req_addr,
  input  logic [31:0] m_req_wdata,
  input  logic [3:0]  m_req_wstrb,
  output logic        m_rsp_valid,
  input  logic        m_rsp_ready,
  output logic [31:0] m_rsp_rdata,
  output logic        m_rsp_err,
  output logic        sram_req_valid,
  output logic        sram_req_we,
  output logic [31:0] sram_req_addr,
  output logic [31:0] sram_req_wdata,
  output logic [3:0]  sram_req_wstrb,
  input  logic        sram_resp_valid,
  input  logic [31:0] sram_resp_rdata,
  input  logic        sram_resp_err,
  output logic [15:0] err_count
);

  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;

  logic          accept;
  logic          bad;
  logic          s1_valid_q;
  logic          s1_err_q;
  logic [15:0]   err_count_q;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  rsp_t          push_rsp;
  rsp_t          head_rsp;

  // Credit counts in-flight s1 entries; the same-cycle pop is ignored
  assign m_req_ready = (32'(fifo_count) + 32'(s1_valid_q)) < RSP_DEPTH;
  assign accept      = m_req_valid && m_req_ready;
  assign bad         = addr_bad(m_req_addr, BASE_ADDR, 32'(WORDS));

  assign sram_req_valid = accept && !bad;
  assign sram_req_we    = m_req_we;
  assign sram_req_addr  = m_req_addr - BASE_ADDR;
  assign sram_req_wdata = m_req_wdata;
  assign sram_req_wstrb = m_req_wstrb;

  always_comb begin
    push_rsp.rdata = sram_resp_rdata;
    push_rsp.err   = sram_resp_err;
    if (s1_err_q) begin
      push_rsp.rdata = 32'h0;
      push_rsp.err   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_err_q   <= bad;
      if (accept && bad && err_count_q != 16'hFFFF)
        err_count_q <= err_count_q + 16'd1;
    end
  end

  boreal_rsp_fifo #(
    .W($bits(rsp_t)),
    .D(RSP_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s1_valid_q),
    .din_i   (push_rsp),
    .pop_i   (m_rsp_valid && m_rsp_ready),
    .dout_o  (head_rsp),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_rsp_valid = !fifo_empty;
  assign m_rsp_rdata = head_rsp.rdata;
  assign m_rsp_err   = head_rsp.err;
  assign err_count   = err_count_q;

  a_tile_proto: assert property (@(posedge clk) disable iff (!rst_n)
    sram_resp_valid == (s1_valid_q && !s1_err_q));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(s1_valid_q && fifo_full && !(m_rsp_valid && m_rsp_ready)));

endmodule

// File: tb/tb_boreal_sram_bridge.sv
// Scoreboard bench for boreal_sram_bridge with a one-cycle tile model.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_boreal_sram_bridge;
  import boreal_sram_pkg::*;

  localparam int unsigned WORDS = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_req_valid = 1'b0;
  logic        m_req_ready;
  logic        m_req_we = 1'b0;
  logic [31:0] m_req_addr = '0;
  logic [31:0] m_req_wdata = '0;
  logic [3:0]  m_req_wstrb = '0;
  logic        m_rsp_valid;
  logic        m_rsp_ready = 1'b1;
  logic [31:0] m_rsp_rdata;
  logic        m_rsp_err;
  logic        sram_req_valid;
  logic        sram_req_we;
  logic [31:0] sram_req_addr;
  logic [31:0] sram_req_wdata;
  logic [3:0]  sram_req_wstrb;
  logic        sram_resp_valid;
  logic [31:0] sram_resp_rdata;
  logic        sram_resp_err;
  logic [15:0] err_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int first_v = -1;
  bit arm = 1'b0;
  rsp_t sb[$];
  logic [31:0] tmem [WORDS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  boreal_sram_bridge #(
    .WORDS(WORDS), .BASE_ADDR(BASE), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_we(m_req_we), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
    .sram_req_valid(sram_req_valid), .sram_req_we(sram_req_we),
    .sram_req_addr(sram_req_addr), .sram_req_wdata(sram_req_wdata),
    .sram_req_wstrb(sram_req_wstrb),
    .sram_resp_valid(sram_resp_valid), .sram_resp_rdata(sram_resp_rdata),
    .sram_resp_err(sram_resp_err), .err_count(err_count)
  );

  // Tile: one-cycle latency, writes answer with zero data
  initial for (int i = 0; i < int'(WORDS); i++) tmem[i] = '0;
  assign sram_resp_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_resp_valid <= 1'b0;
      sram_resp_rdata <= '0;
    end else begin
      sram_resp_valid <= sram_req_valid;
      if (sram_req_valid)
        sram_resp_rdata <= sram_req_we ? 32'h0
                                       : tmem[sram_req_addr[11:2]];
    end
  end

  always @(posedge clk) begin
    if (rst_n && sram_req_valid && sram_req_we)
      for (int b = 0; b < 4; b++)
        if (sram_req_wstrb[b])
          tmem[sram_req_addr[11:2]][b*8 +: 8] <= sram_req_wdata[b*8 +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop expected on every handshake
  always @(negedge clk) begin
    if (arm && first_v < 0 && m_rsp_valid) first_v = cyc;
    if (rst_n && m_rsp_valid && m_rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got %h/%b expected none",
                 m_rsp_rdata, m_rsp_err);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        if (m_rsp_rdata !== e.rdata || m_rsp_err !== e.err) begin
          failures++;
          $display("FAIL rsp_data: got %h/%b expected %h/%b",
                   m_rsp_rdata, m_rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  // Issue one request; called at posedge+1, returns at posedge+1
  task automatic req(input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] er, input logic ee,
                     input logic [31:0] eoff);
    int n;
    rsp_t r;
    m_req_valid = 1'b1;
    m_req_we    = we;
    m_req_addr  = a;
    m_req_wdata = d;
    m_req_wstrb = s;
    n = 0;
    forever begin
      @(negedge clk);
      if (m_req_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL req_timeout: got ready=0 expected ready=1");
        break;
      end
    end
    if (m_req_ready) begin
      chk("sram_req_valid", 32'(sram_req_valid), 32'(!ee));
      if (!ee) chk("sram_req_addr", sram_req_addr, eoff);
      r.rdata = er;
      r.err   = ee;
      sb.push_back(r);
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    m_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_rsp_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int acc;
    int t0;
    rsp_t r;
    #3;
    chk("rst_req_ready", 32'(m_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", m_rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(m_rsp_err), 32'd0);
    chk("rst_sram_valid", 32'(sram_req_valid), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write then read back
    req(1'b1, 32'h1008, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 32'h8);
    req(1'b0, 32'h1008, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 32'h8);
    req(1'b1, 32'h1010, 32'h11, 4'hF, 32'h0, 1'b0, 32'h10);
    req(1'b1, 32'h1014, 32'h22, 4'hF, 32'h0, 1'b0, 32'h14);
    // Zero-strobe write leaves the word intact
    req(1'b1, 32'h1010, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 32'h10);
    req(1'b0, 32'h1010, 32'h0, 4'h0, 32'h11, 1'b0, 32'h10);
    drain();

    // Range and alignment errors
    req(1'b0, 32'h0FFC, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0);
    req(1'b0, BASE + WORDS * 4, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0);
    req(1'b0, 32'h1002, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0);
    chk("err_count_3", 32'(err_count), 32'd3);
    // Last word is still in range
    req(1'b0, BASE + WORDS * 4 - 4, 32'h0, 4'h0, 32'h0, 1'b0, 32'hFFC);
    drain();

    // Interleaved good/bad ordering
    req(1'b0, 32'h1010, 32'h0, 4'h0, 32'h11, 1'b0, 32'h10);
    req(1'b0, 32'h0800, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0);
    req(1'b0, 32'h1014, 32'h0, 4'h0, 32'h22, 1'b0, 32'h14);
    drain();
    chk("err_count_4", 32'(err_count), 32'd4);

    // Backpressure: exactly DEPTH accepts while rsp_ready is low
    m_rsp_ready = 1'b0;
    m_req_valid = 1'b1;
    m_req_we    = 1'b0;
    m_req_addr  = 32'h1010;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_req_ready) begin
        acc++;
        r.rdata = 32'h11;
        r.err   = 1'b0;
        sb.push_back(r);
      end
      @(posedge clk);
      #1;
    end
    m_req_valid = 1'b0;
    chk("bp_accepts", 32'(acc), 32'(DEPTH));
    chk("bp_ready_low", 32'(m_req_ready), 32'd0);
    chk("bp_held_valid", 32'(m_rsp_valid), 32'd1);
    m_rsp_ready = 1'b1;
    drain();
    req(1'b0, 32'h1014, 32'h0, 4'h0, 32'h22, 1'b0, 32'h14);
    drain();

    // Streaming: 16 back-to-back reads
    first_v = -1;
    arm = 1'b1;
    t0 = 0;
    for (int i = 0; i < 16; i++) begin
      req(1'b0, 32'h1008, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 32'h8);
      if (i == 0) t0 = acc_cyc;
    end
    chk("stream_cycles", 32'(acc_cyc - t0), 32'd15);
    drain();
    arm = 1'b0;
    chk("stream_latency", 32'(first_v - t0), 32'd2);

    // Reset mid-stream with three responses queued
    m_rsp_ready = 1'b0;
    req(1'b0, 32'h1014, 32'h0, 4'h0, 32'h22, 1'b0, 32'h14);
    req(1'b0, 32'h3000, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0);
    req(1'b0, 32'h1010, 32'h0, 4'h0, 32'h11, 1'b0, 32'h10);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(m_rsp_valid), 32'd1);
    chk("pre_rst_errs", 32'(err_count), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(m_req_ready), 32'd1);
    chk("mid_rst_errs", 32'(err_count), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(m_rsp_valid), 32'd0);
    req(1'b0, 32'h1008, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 32'h8);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boreal_sram_bridge.md
# boreal_sram_bridge

Request/response front-end that sits directly upstream of the 32-bit SRAM tile. It accepts word requests from a master over a valid/ready handshake, range- and alignment-checks them, and issues legal requests to the tile, which has a fixed one-cycle response latency. It queues tile responses and locally generated error responses, strictly in request order, in a response FIFO drained by the master over a valid/ready handshake. Backpressure is credit-based, so no response is ever dropped.

## Interface
- WORDS, 1024, tile depth in 32-bit words; power of two, ≥ 2
- BASE_ADDR, 32'h0000_0000, byte address of tile word 0; aligned to WORDS*4
- RSP_DEPTH, 4, response FIFO entries; power of two, ≥ 2 (≥ 4 for full throughput)

- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- m_req_valid  in  1  master request valid
- m_req_ready  out  1  bridge can accept this cycle
- m_req_we  in  1  1 = write, 0 = read
- m_req_addr  in  32  byte address
- m_req_wdata  in  32  write data
- m_req_wstrb  in  4  byte enables
- m_rsp_valid  out  1  response available (FIFO head)
- m_rsp_ready  in  1  master consumes response
- m_rsp_rdata  out  32  read data (tile word; 0 on error)
- m_rsp_err  out  1  1 = request rejected (range or alignment)
- sram_req_valid  out  1  to tile
- sram_req_we  out  1  to tile
- sram_req_addr  out  32  to tile, byte offset from BASE_ADDR
- sram_req_wdata  out  32  to tile
- sram_req_wstrb  out  4  to tile
- sram_resp_valid  in  1  from tile
- sram_resp_rdata  in  32  from tile
- sram_resp_err  in  1  from tile, ORed into m_rsp_err
- err_count  out  16  saturating count of rejected requests

## Operation
- Accept condition: accept = m_req_valid && m_req_ready.
- Ready rule: m_req_ready = (fifo_count + s1_valid) < RSP_DEPTH. The same-cycle pop is not credited, so ready depends only on registered state.
- Offset: off = m_req_addr − BASE_ADDR, modulo 2^32.
- Error rule: bad = (off ≥ WORDS*4) || (m_req_addr[1:0] != 0).
- Tile drive (combinational, same cycle as accept):
  - sram_req_valid = accept && !bad.
  - sram_req_addr = off.
  - we, wdata and wstrb pass through unchanged.
- wstrb = 0 on a write is legal and forwarded; the tile write is a no-op.
- Stage s1 is a register set {s1_valid, s1_err}, loaded every cycle with {accept, bad}.
- FIFO push when s1_valid:
  - s1_err = 0: push {sram_resp_rdata, sram_resp_err}.
  - s1_err = 1: push {32'h0, 1}.
- If sram_resp_valid != (s1_valid && !s1_err), treat it as a protocol fault: assertion in simulation, no RTL recovery.
- err_count increments on each accept with bad = 1 and saturates at 16'hFFFF.
- m_rsp_* are driven from the FIFO head. Pop when m_rsp_valid && m_rsp_ready.

## Timing
- Reset values: m_req_ready = 1, m_rsp_valid = 0, m_rsp_rdata = 0, m_rsp_err = 0, sram_req_valid = 0, err_count = 0. FIFO pointers, count, s1_valid and s1_err are all 0.
- Latency, accept at cycle T:
  - Tile samples at edge T→T+1.
  - Response pushed at edge T+1→T+2.
  - m_rsp_valid is first high in cycle T+2, for a minimum request-to-response latency of 2.
- Throughput with RSP_DEPTH ≥ 4 and m_rsp_ready held 1: one request per cycle, steady fifo_count = 1.
- Throughput with RSP_DEPTH = 2: 2 accepts per 3 cycles.
- Ordering: responses leave in strict accept order, including interleaved error responses.
- FIFO full: the credit rule guarantees a push never meets a full FIFO. Push and pop in the same cycle leave the count unchanged.
- FIFO empty: m_rsp_valid = 0; m_rsp_rdata and m_rsp_err hold their last value.
- Pointers wrap modulo RSP_DEPTH.
- Reset assertion mid-operation clears everything immediately; in-flight and queued responses are discarded. The tile's own synchronous reset is sequenced externally.

## Structure
- Package boreal_sram_pkg holds:
  - WORD_BYTES = 4.
  - The response struct {rdata[31:0], err}.
  - Function addr_bad(addr, base, words).
- Sub-module boreal_rsp_fifo:
  - Parameterised width and depth, async reset.
  - Outputs count, full and empty.
  - The head is presented combinationally from storage.
- The bridge top contains only the address check, stage s1, the credit logic and err_count.

## Test plan
- Write then read, BASE_ADDR = 0x1000: write 0x1008 = 0xDEADBEEF with wstrb 0xF, then read 0x1008 → rsp0 {0, err 0}, rsp1 {0xDEADBEEF, 0}; sram_req_addr = 0x8.
- Range and alignment errors: reads at 0x0FFC, at 0x1000 + WORDS*4, and at 0x1002 → three responses {0, 1}; sram_req_valid stays 0 for all three; err_count = 3.
- Interleaved order: good, bad, good reads of words holding 0x11 and 0x22 → responses {0x11, 0}, {0, 1}, {0x22, 0} in that order.
- Backpressure, RSP_DEPTH = 4: hold m_rsp_ready = 0 and stream reads.
  - Exactly 4 accepted; m_req_ready falls the cycle the 4th is accepted.
  - Release m_rsp_ready → 4 responses, then accepts resume.
- Streaming with m_rsp_ready = 1: 16 back-to-back reads → 16 accepts in 16 cycles; first m_rsp_valid 2 cycles after the first accept.
- Reset mid-stream: drop rst_n with 3 responses queued → m_rsp_valid = 0 and m_req_ready = 1 at once; after release, no stale responses appear; err_count = 0.
